// File: rtl/dl_enc_pkg.sv
// Shared widths and types for the pending-vector encoder slice.
package dl_enc_pkg;

  localparam int ENC_OUT_W = 5;
  localparam int ENC_IN_W  = 32;

  typedef logic [ENC_OUT_W-1:0] enc_idx_t;
  typedef logic [ENC_IN_W-1:0]  enc_vec_t;

endpackage

// File: rtl/dl_ffs_32p5p.sv
// Combinational find-first-set: reports the lowest set bit of vec and whether any bit is set.
module dl_ffs_32p5p
  import dl_enc_pkg::*;
#(
  parameter int W_IDX = ENC_OUT_W,
  parameter int W_VEC = 2**W_IDX
) (
  input  logic [W_VEC-1:0] vec,
  output logic [W_IDX-1:0] idx,
  output logic             found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = W_VEC-1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = W_IDX'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dl_pend_encoder_32p5p.sv
// Sequential 32-to-5 encoder: accumulates event bits into a pending vector and
// hands them out one index at a time over a valid/ready handshake.
// Build option: define DL_PEND_ENC_RR_EN for round-robin selection; otherwise the
// lowest pending index is always presented first.
module dl_pend_encoder_32p5p
  import dl_enc_pkg::*;
#(
  parameter int OUTPUT_WIDTH = ENC_OUT_W,
  parameter int INPUT_WIDTH  = 2**OUTPUT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_vld,
  input  logic [INPUT_WIDTH-1:0]  in,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [OUTPUT_WIDTH-1:0] out_idx,
  output logic [INPUT_WIDTH-1:0]  pend,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  logic                    pop;
  logic [INPUT_WIDTH-1:0]  clr_mask;
  logic [INPUT_WIDTH-1:0]  set_mask;
  logic [INPUT_WIDTH-1:0]  pend_d;
  logic                    ovf_d;
  logic [OUTPUT_WIDTH-1:0] sel_idx;
  logic                    sel_found;

  assign pop      = out_vld & out_rdy;
  assign set_mask = in_vld ? in : '0;
  // A set on the same bit as the retiring pop keeps the bit pending.
  assign pend_d   = (pend & ~clr_mask) | set_mask;

  // Retire only the index being accepted this cycle.
  always_comb begin
    clr_mask = '0;
    if (pop) clr_mask[out_idx] = 1'b1;
  end

  // Sticky overflow: a new overflow beats a simultaneous clear.
  always_comb begin
    ovf_d = ovf;
    if (ovf_clr) ovf_d = 1'b0;
    if ((set_mask & pend & ~clr_mask) != '0) ovf_d = 1'b1;
  end

`ifdef DL_PEND_ENC_RR_EN
  logic [OUTPUT_WIDTH-1:0] ptr;
  logic [OUTPUT_WIDTH-1:0] ptr_d;
  logic [INPUT_WIDTH-1:0]  hi_mask;
  logic [OUTPUT_WIDTH-1:0] idx_hi;
  logic [OUTPUT_WIDTH-1:0] idx_all;
  logic                    found_hi;
  logic                    found_all;

  // The search starts just past the index accepted this cycle, so the
  // bit just served goes to the back of the line immediately.
  assign ptr_d = pop ? out_idx : ptr;

  // Bits strictly above the pointer form the first search window.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) hi_mask[i] = (i > int'(ptr_d));
  end

  dl_ffs_32p5p #(.W_IDX(OUTPUT_WIDTH)) u_ffs_hi (
    .vec   (pend_d & hi_mask),
    .idx   (idx_hi),
    .found (found_hi)
  );

  dl_ffs_32p5p #(.W_IDX(OUTPUT_WIDTH)) u_ffs_all (
    .vec   (pend_d),
    .idx   (idx_all),
    .found (found_all)
  );

  assign sel_idx   = found_hi ? idx_hi : idx_all;
  assign sel_found = found_all;

  // Round-robin pointer remembers the last accepted index; reset points at the top bit.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= '1;
    else        ptr <= ptr_d;
  end
`else
  dl_ffs_32p5p #(.W_IDX(OUTPUT_WIDTH)) u_ffs (
    .vec   (pend_d),
    .idx   (sel_idx),
    .found (sel_found)
  );
`endif

  // Pending vector and presented index are both registered from pend_d, so an
  // accept or a new event is reflected one edge later with no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend    <= '0;
      out_vld <= 1'b0;
      out_idx <= '0;
      ovf     <= 1'b0;
    end else begin
      pend    <= pend_d;
      out_vld <= sel_found;
      if (sel_found) out_idx <= sel_idx;
      ovf     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_dl_pend_encoder_32p5p.sv
// Self-checking bench for dl_pend_encoder_32p5p (honours DL_PEND_ENC_RR_EN).
module tb_dl_pend_encoder_32p5p;

  typedef struct {
    logic        rstn;
    logic        iv;
    logic [31:0] din;
    logic        rdy;
    logic        clr;
  } stim_t;

  typedef struct {
    logic        vld;
    logic [4:0]  idx;
    logic [31:0] pend;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic [31:0] in = '0;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [4:0]  out_idx;
  logic [31:0] pend;
  logic        ovf;
  logic        ovf_clr = 1'b0;

  int n_tot = 0;
  int n_bad = 0;

  exp_t sbq[$];

  logic [31:0] m_pend = '0;
  logic        m_vld  = 1'b0;
  logic [4:0]  m_idx  = '0;
  logic        m_ovf  = 1'b0;
`ifdef DL_PEND_ENC_RR_EN
  logic [4:0]  m_ptr  = 5'd31;
`endif

  dl_pend_encoder_32p5p dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in      (in),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_idx (out_idx),
    .pend    (pend),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

`ifdef DL_PEND_ENC_RR_EN
  // Reference round-robin pick: walk forward from p+1 with wrap.
  function automatic void msel(input logic [31:0] v, input logic [4:0] p,
                               output logic f, output logic [4:0] ix);
    f = 1'b0; ix = '0;
    for (int k = 1; k <= 32; k++) begin
      int j;
      j = (int'(p) + k) % 32;
      if (!f && v[j]) begin f = 1'b1; ix = 5'(j); end
    end
  endfunction
`else
  // Reference fixed-priority pick: lowest index wins.
  function automatic void msel(input logic [31:0] v, output logic f, output logic [4:0] ix);
    f = 1'b0; ix = '0;
    for (int j = 0; j < 32; j++)
      if (!f && v[j]) begin f = 1'b1; ix = 5'(j); end
  endfunction
`endif

  // Drive one cycle of stimulus, advance the reference model and queue its expectation.
  task automatic drv(input stim_t s);
    exp_t        e;
    logic        pop, f;
    logic [31:0] cm, sm, np;
    logic [4:0]  ix;
    @(negedge clk);
    rst_n = s.rstn; in_vld = s.iv; in = s.din; out_rdy = s.rdy; ovf_clr = s.clr;
    if (!s.rstn) begin
      m_pend = '0; m_vld = 1'b0; m_idx = '0; m_ovf = 1'b0;
`ifdef DL_PEND_ENC_RR_EN
      m_ptr = 5'd31;
`endif
    end else begin
      pop = m_vld & s.rdy;
      cm  = pop ? (32'h1 << m_idx) : 32'h0;
      sm  = s.iv ? s.din : 32'h0;
      np  = (m_pend & ~cm) | sm;
      if ((sm & m_pend & ~cm) != 32'h0) m_ovf = 1'b1;
      else if (s.clr)                   m_ovf = 1'b0;
`ifdef DL_PEND_ENC_RR_EN
      if (pop) m_ptr = m_idx;
      msel(np, m_ptr, f, ix);
`else
      msel(np, f, ix);
`endif
      m_pend = np;
      m_vld  = f;
      if (f) m_idx = ix;
    end
    e.vld = m_vld; e.idx = m_idx; e.pend = m_pend; e.ovf = m_ovf;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic take(output exp_t e, output bit ok);
    e = '{default: '0};
    ok = 1'b0;
    if (sbq.size() != 0) begin
      e  = sbq.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    stim_t s [2];
    exp_t  e;
    bit    ok;
    s[0] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    s[1] = '{1'b0, 1'b1, 32'h0000_00FF, 1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      drv(s[i]); take(e, ok);
      n_tot++;
      if (!ok || out_vld !== 1'b0 || out_idx !== 5'd0 || pend !== 32'h0 || ovf !== 1'b0 ||
          out_vld !== e.vld || pend !== e.pend) begin
        n_bad++;
        $display("FAIL reset[%0d] got vld=%b idx=%0d pend=%h ovf=%b want vld=0 idx=0 pend=0 ovf=0",
                 i, out_vld, out_idx, pend, ovf);
      end
    end
  endtask

  task automatic test_single();
    stim_t s [2];
    exp_t  e;
    bit    ok;
    s[0] = '{1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    s[1] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      drv(s[i]); take(e, ok);
      n_tot++;
      if (!ok || out_vld !== e.vld || out_idx !== e.idx || pend !== e.pend || ovf !== e.ovf) begin
        n_bad++;
        $display("FAIL single[%0d] got vld=%b idx=%0d pend=%h ovf=%b want vld=%b idx=%0d pend=%h ovf=%b",
                 i, out_vld, out_idx, pend, ovf, e.vld, e.idx, e.pend, e.ovf);
      end
    end
  endtask

  task automatic test_sequence();
    stim_t      s [5];
    logic [4:0] seq [3];
    exp_t       e;
    bit         ok;
    seq[0] = 5'd0; seq[1] = 5'd4; seq[2] = 5'd31;
    s[0] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    s[1] = '{1'b1, 1'b1, 32'h8000_0011, 1'b1, 1'b0};
    s[2] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    s[3] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    s[4] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drv(s[i]); take(e, ok);
      n_tot++;
      if (!ok || out_vld !== e.vld || out_idx !== e.idx || pend !== e.pend || ovf !== e.ovf) begin
        n_bad++;
        $display("FAIL sequence[%0d] got vld=%b idx=%0d pend=%h ovf=%b want vld=%b idx=%0d pend=%h ovf=%b",
                 i, out_vld, out_idx, pend, ovf, e.vld, e.idx, e.pend, e.ovf);
      end
      if (i >= 1 && i <= 3) begin
        n_tot++;
        if (out_vld !== 1'b1 || out_idx !== seq[i-1]) begin
          n_bad++;
          $display("FAIL sequence_idx[%0d] got vld=%b idx=%0d want vld=1 idx=%0d",
                   i-1, out_vld, out_idx, seq[i-1]);
        end
      end
    end
    n_tot++;
    if (out_vld !== 1'b0 || pend !== 32'h0) begin
      n_bad++;
      $display("FAIL sequence_empty got vld=%b pend=%h want vld=0 pend=0", out_vld, pend);
    end
  endtask

  task automatic test_preempt();
    stim_t s [4];
    exp_t  e;
    bit    ok;
    s[0] = '{1'b1, 1'b1, 32'h0000_0010, 1'b0, 1'b0};
    s[1] = '{1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    s[2] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    s[3] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drv(s[i]); take(e, ok);
      n_tot++;
      if (!ok || out_vld !== e.vld || out_idx !== e.idx || pend !== e.pend || ovf !== e.ovf) begin
        n_bad++;
        $display("FAIL preempt[%0d] got vld=%b idx=%0d pend=%h ovf=%b want vld=%b idx=%0d pend=%h ovf=%b",
                 i, out_vld, out_idx, pend, ovf, e.vld, e.idx, e.pend, e.ovf);
      end
    end
  endtask

  task automatic test_set_wins();
    stim_t s [7];
    exp_t  e;
    bit    ok;
    s[0] = '{1'b1, 1'b1, 32'h0000_0008, 1'b0, 1'b0};
    s[1] = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 1'b0};
    s[2] = '{1'b1, 1'b1, 32'h0000_0008, 1'b0, 1'b0};
    s[3] = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    s[4] = '{1'b1, 1'b1, 32'h0000_0008, 1'b0, 1'b1};
    s[5] = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
    s[6] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drv(s[i]); take(e, ok);
      n_tot++;
      if (!ok || out_vld !== e.vld || out_idx !== e.idx || pend !== e.pend || ovf !== e.ovf) begin
        n_bad++;
        $display("FAIL set_wins[%0d] got vld=%b idx=%0d pend=%h ovf=%b want vld=%b idx=%0d pend=%h ovf=%b",
                 i, out_vld, out_idx, pend, ovf, e.vld, e.idx, e.pend, e.ovf);
      end
    end
  endtask

  task automatic test_full_reset();
    stim_t s [5];
    exp_t  e;
    bit    ok;
    s[0] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    s[1] = '{1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    s[2] = '{1'b1, 1'b1, 32'h0000_0002, 1'b0, 1'b0};
    s[3] = '{1'b0, 1'b1, 32'h0000_00FF, 1'b1, 1'b0};
    s[4] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drv(s[i]); take(e, ok);
      n_tot++;
      if (!ok || out_vld !== e.vld || out_idx !== e.idx || pend !== e.pend || ovf !== e.ovf) begin
        n_bad++;
        $display("FAIL full_reset[%0d] got vld=%b idx=%0d pend=%h ovf=%b want vld=%b idx=%0d pend=%h ovf=%b",
                 i, out_vld, out_idx, pend, ovf, e.vld, e.idx, e.pend, e.ovf);
      end
    end
  endtask

`ifdef DL_PEND_ENC_RR_EN
  task automatic test_rr();
    stim_t      s [5];
    logic [4:0] want [5];
    exp_t       e;
    bit         ok;
    s[0] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    s[1] = '{1'b1, 1'b1, 32'h0000_0005, 1'b0, 1'b0};
    s[2] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    s[3] = '{1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    s[4] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    want[0] = 5'd0; want[1] = 5'd0; want[2] = 5'd2; want[3] = 5'd2; want[4] = 5'd0;
    for (int i = 0; i < 5; i++) begin
      drv(s[i]); take(e, ok);
      n_tot++;
      if (!ok || out_idx !== want[i] || out_vld !== e.vld || pend !== e.pend || out_idx !== e.idx) begin
        n_bad++;
        $display("FAIL rr[%0d] got vld=%b idx=%0d pend=%h want vld=%b idx=%0d pend=%h",
                 i, out_vld, out_idx, pend, e.vld, want[i], e.pend);
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    stim_t s;
    exp_t  e;
    bit    ok;
    for (int i = 0; i < 400; i++) begin
      s.rstn = ($urandom_range(0, 199) != 0);
      s.iv   = ($urandom_range(0, 2) == 0);
      s.din  = $urandom & $urandom & $urandom;
      s.rdy  = ($urandom_range(0, 3) != 0);
      s.clr  = ($urandom_range(0, 7) == 0);
      drv(s); take(e, ok);
      n_tot++;
      if (!ok || out_vld !== e.vld || out_idx !== e.idx || pend !== e.pend || ovf !== e.ovf) begin
        n_bad++;
        $display("FAIL back_to_back[%0d] got vld=%b idx=%0d pend=%h ovf=%b want vld=%b idx=%0d pend=%h ovf=%b",
                 i, out_vld, out_idx, pend, ovf, e.vld, e.idx, e.pend, e.ovf);
      end
      if (out_vld === 1'b1 && pend[out_idx] !== 1'b1) begin
        n_tot++;
        n_bad++;
        $display("FAIL presented_bit_pending[%0d] got pend=%h idx=%0d want bit set", i, pend, out_idx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_preempt();
    test_set_wins();
    test_full_reset();
`ifdef DL_PEND_ENC_RR_EN
    test_rr();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
